// File: rtl/move_scheduler.sv
// Move-request scheduler: merges key/gravity pulses into pending bits and issues one
// board command at a time over valid/ready. Define KEY_RR_EN for round-robin key arbitration.
module move_scheduler #(
  parameter int unsigned GRAV_BASE    = 50_000_000,
  parameter int unsigned GRAV_STEP    = 4_000_000,
  parameter int unsigned GRAV_MIN     = 5_000_000,
  parameter int unsigned DONE_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_rot,
  input  logic       key_down,
  input  logic [3:0] level,
  input  logic       pause,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  input  logic       cmd_ready,
  input  logic       mv_done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LEFT  = 3'd1,
    OP_RIGHT = 3'd2,
    OP_ROT   = 3'd3,
    OP_DOWN  = 3'd4,
    OP_GRAV  = 3'd5
  } op_t;

  // Key slots are indexed in round-robin order: 0=ROT 1=LEFT 2=RIGHT 3=DOWN.
  function automatic logic [2:0] key_op(input logic [1:0] idx);
    unique case (idx)
      2'd0:    key_op = OP_ROT;
      2'd1:    key_op = OP_LEFT;
      2'd2:    key_op = OP_RIGHT;
      default: key_op = OP_DOWN;
    endcase
  endfunction

  state_t      state;
  logic [3:0]  pend_key;
  logic        pend_grav;
  logic [31:0] grav_cnt;
  logic [31:0] grav_drop;
  logic [31:0] grav_period;
  logic        grav_tick;
  logic [31:0] done_cnt;
  logic        grant_grav;
  logic [1:0]  grant_idx;
  logic [1:0]  rr_ptr;
  logic [1:0]  cand;
  logic [1:0]  key_idx;
  logic        key_any;
  logic        xfer;
  logic [3:0]  key_pulse;
  logic [3:0]  clr_key;

  assign key_pulse = {key_down, key_right, key_left, key_rot};
  assign xfer      = cmd_valid && cmd_ready;
  assign clr_key   = (xfer && !grant_grav) ? (4'b0001 << grant_idx) : 4'b0000;

  // Period clamps to the floor before the subtraction could underflow.
  always_comb begin
    grav_drop = 32'(level) * GRAV_STEP;
    if (grav_drop >= GRAV_BASE || (GRAV_BASE - grav_drop) < GRAV_MIN)
      grav_period = GRAV_MIN;
    else
      grav_period = GRAV_BASE - grav_drop;
  end

  // ">=" rather than "==" so a level increase past the current count ticks at once.
  assign grav_tick = !pause && (grav_cnt >= grav_period - 32'd1);

  // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking (<=)
  // so every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      grav_cnt <= 32'd0;
    end else if (!pause) begin
      grav_cnt <= grav_tick ? 32'd0 : grav_cnt + 32'd1;
    end
  end

  // NOTE: clear is applied before set, so a new pulse on the grant edge keeps the bit.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pend_key  <= 4'b0000;
      pend_grav <= 1'b0;
    end else begin
      pend_key  <= (pend_key & ~clr_key) | (key_pulse & {4{!pause}});
      pend_grav <= (pend_grav & ~(xfer && grant_grav)) | grav_tick;
    end
  end

`ifdef KEY_RR_EN
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)
      rr_ptr <= 2'd0;
    else if (xfer && !grant_grav)
      rr_ptr <= grant_idx + 2'd1;
  end
`else
  assign rr_ptr = 2'd0;
`endif

  // Search from the pointer; iterating downwards lets the nearest pending slot win.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    key_any = 1'b0;
    key_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr + 2'(i);
      if (pend_key[cand]) begin
        key_any = 1'b1;
        key_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      cmd_valid   <= 1'b0;
      cmd_op      <= OP_NONE;
      timeout_err <= 1'b0;
      done_cnt    <= 32'd0;
      grant_grav  <= 1'b0;
      grant_idx   <= 2'd0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!pause && (pend_grav || key_any)) begin
            grant_grav <= pend_grav;
            grant_idx  <= key_idx;
            cmd_op     <= pend_grav ? OP_GRAV : key_op(key_idx);
            cmd_valid  <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NONE;
            done_cnt  <= 32'd0;
            state     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (mv_done) begin
            state <= S_IDLE;
          end else if (done_cnt == 32'(DONE_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            done_cnt <= done_cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: scoreboard of expected cmd_op values,
// popped at each observed valid/ready transfer; small gravity/timeout parameters.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       key_left, key_right, key_rot, key_down;
  logic [3:0] level;
  logic       pause;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       mv_done;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];
  logic       s_valid;
  logic [2:0] s_op;
  logic       s_terr;
  logic       xfer;
  bit         auto_done;
  int         done_cnt;
  int         done_delay;

  move_scheduler #(
    .GRAV_BASE   (100),
    .GRAV_STEP   (10),
    .GRAV_MIN    (30),
    .DONE_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_rot    (key_rot),
    .key_down   (key_down),
    .level      (level),
    .pause      (pause),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .mv_done    (mv_done),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  // Sample at negedge (state after last edge; xfer = transfer at the coming edge),
  // then after the edge clear key pulses and play the engine's mv_done.
  task automatic step();
    @(negedge clk);
    s_valid = cmd_valid;
    s_op    = cmd_op;
    s_terr  = timeout_err;
    xfer    = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
    @(posedge clk);
    #1;
    key_left = 1'b0; key_right = 1'b0; key_rot = 1'b0; key_down = 1'b0;
    mv_done  = 1'b0;
    if (xfer && auto_done) done_cnt = done_delay;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) mv_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_rot = 1'b0; key_down = 1'b0;
    level = 4'd0; pause = 1'b0; cmd_ready = 1'b0; mv_done = 1'b0;
    auto_done = 1'b1; done_delay = 1; done_cnt = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s_valid); end
    checks++;
    if (s_op !== 3'd0) begin errors++; $display("FAIL reset_op: got %0d want 0", s_op); end
    checks++;
    if (s_terr !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", s_terr); end
  endtask

  task automatic test_single_left();
    logic [2:0] e;
    int n_xfer = 0;
    do_reset();
    cmd_ready = 1'b1;
    key_left = 1'b1;
    exp_q.push_back(3'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k >= 2 && k <= 4) begin
        checks++;
        if (s_valid !== 1'(k == 3)) begin
          errors++; $display("FAIL single_latency step %0d: cmd_valid=%b want %b", k, s_valid, (k == 3));
        end
      end
      if (xfer) begin
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL single_sb: unexpected cmd_op=%0d", s_op);
        end else begin
          e = exp_q.pop_front();
          if (s_op !== e) begin errors++; $display("FAIL single_sb: cmd_op=%0d want %0d", s_op, e); end
        end
      end
    end
    checks++;
    if (n_xfer != 1) begin errors++; $display("FAIL single_count: %0d transfers want 1", n_xfer); end
  endtask

  task automatic test_grav_priority();
    logic [2:0] e;
    bit seen = 1'b0;
    do_reset();
    level = 4'd9;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = (s_valid === 1'b1);
    end
    checks++;
    if (!seen || s_op !== 3'd5) begin
      errors++; $display("FAIL grav_first: seen=%b cmd_op=%0d want 5", seen, s_op);
    end
    key_rot = 1'b1; key_down = 1'b1; cmd_ready = 1'b1;
    exp_q.push_back(3'd5); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    for (int k = 0; k < 16; k++) begin
      step();
      if (xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL prio_sb: unexpected cmd_op=%0d", s_op);
        end else begin
          e = exp_q.pop_front();
          if (s_op !== e) begin errors++; $display("FAIL prio_sb: cmd_op=%0d want %0d", s_op, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL prio_missing: %0d commands not seen want 0", exp_q.size()); end
  endtask

  task automatic test_key_arb();
    logic [2:0] e;
    do_reset();
    cmd_ready = 1'b1;
`ifdef KEY_RR_EN
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
`else
    exp_q.push_back(3'd1); exp_q.push_back(3'd1); exp_q.push_back(3'd1); exp_q.push_back(3'd1);
`endif
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      key_left = 1'b1; key_right = 1'b1;
      step();
      if (xfer) begin
        checks++;
        e = exp_q.pop_front();
        if (s_op !== e) begin errors++; $display("FAIL arb_sb: cmd_op=%0d want %0d", s_op, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL arb_missing: %0d commands not seen want 0", exp_q.size()); end
  endtask

  task automatic test_gravity_pause();
    logic [2:0] e;
    int exp_step[4] = '{32, 62, 92, 172};
    int idx = 0;
    bit quiet = 1'b1;
    do_reset();
    level = 4'd9;
    cmd_ready = 1'b1;
    repeat (4) exp_q.push_back(3'd5);
    for (int k = 1; k <= 180; k++) begin
      pause = (k >= 96 && k <= 145);
      if (k == 100) key_left = 1'b1;
      step();
      if (k >= 96 && k <= 146 && s_valid !== 1'b0) quiet = 1'b0;
      if (xfer) begin
        checks++;
        if (idx >= 4 || k != exp_step[idx]) begin
          errors++; $display("FAIL grav_timing: transfer at step %0d want %0d", k, (idx < 4) ? exp_step[idx] : -1);
        end
        idx++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL grav_sb: unexpected cmd_op=%0d", s_op);
        end else begin
          e = exp_q.pop_front();
          if (s_op !== e) begin errors++; $display("FAIL grav_sb: cmd_op=%0d want %0d", s_op, e); end
        end
      end
    end
    pause = 1'b0;
    checks++;
    if (!quiet) begin errors++; $display("FAIL pause_quiet: cmd_valid=1 during pause want 0"); end
    checks++;
    if (idx != 4) begin errors++; $display("FAIL grav_count: %0d transfers want 4", idx); end
  endtask

  task automatic test_ready_stall();
    logic [2:0] e;
    bit seen = 1'b0;
    do_reset();
    key_left = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (s_valid === 1'b1);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (s_valid !== 1'b1 || s_op !== 3'd1) begin
        errors++; $display("FAIL stall_hold step %0d: valid=%b op=%0d want 1/1", k, s_valid, s_op);
      end
    end
    cmd_ready = 1'b1;
    key_left = 1'b1;
    exp_q.push_back(3'd1); exp_q.push_back(3'd1);
    for (int k = 0; k < 15; k++) begin
      step();
      if (xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_sb: unexpected cmd_op=%0d", s_op);
        end else begin
          e = exp_q.pop_front();
          if (s_op !== e) begin errors++; $display("FAIL stall_sb: cmd_op=%0d want %0d", s_op, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_regrant: %0d commands not seen want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    logic [2:0] e;
    bit seen = 1'b0;
    do_reset();
    cmd_ready = 1'b1;
    auto_done = 1'b0;
    key_right = 1'b1;
    exp_q.push_back(3'd2);
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = xfer;
    end
    checks++;
    if (!seen || s_op !== 3'd2) begin
      errors++; $display("FAIL timeout_cmd: seen=%b cmd_op=%0d want 2", seen, s_op);
    end
    void'(exp_q.pop_front());
    for (int j = 1; j <= 18; j++) begin
      step();
      checks++;
      if (s_terr !== 1'(j == 17) || s_valid !== 1'b0) begin
        errors++; $display("FAIL timeout_pulse +%0d: terr=%b valid=%b want %b/0", j, s_terr, s_valid, (j == 17));
      end
      if (j == 17) begin
        key_rot = 1'b1; auto_done = 1'b1;
        exp_q.push_back(3'd3);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (xfer) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL timeout_sb: unexpected cmd_op=%0d", s_op);
        end else begin
          e = exp_q.pop_front();
          if (s_op !== e) begin errors++; $display("FAIL timeout_sb: cmd_op=%0d want %0d", s_op, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_idle: %0d commands not seen want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    key_down = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (s_valid === 1'b1);
    end
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (!seen || cmd_valid !== 1'b0 || cmd_op !== 3'd0) begin
      errors++; $display("FAIL reset_mid: seen=%b valid=%b op=%0d want 1/0/0", seen, cmd_valid, cmd_op);
    end
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b1;
    done_cnt = 0;
    mv_done = 1'b0;
    cmd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (xfer) begin
        checks++;
        errors++; $display("FAIL reset_mid_sb: unexpected cmd_op=%0d after reset", s_op);
      end
    end
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_pend: cmd_valid=%b want 0", s_valid); end
  endtask

  initial begin
    test_reset();
    test_single_left();
    test_grav_priority();
    test_key_arb();
    test_gravity_pause();
    test_ready_stall();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequences all piece-move requests into the Tetris board logic. Collects single-cycle pulses from the four debounced move keys and an internal gravity timer, holds them as pending requests, arbitrates, and issues one move command at a time to the board update engine over a valid/ready handshake, then waits for the engine's completion pulse. It sits between the per-key debounce/repeat blocks and the board/collision controller.

## Interface
- GRAV_BASE, 50000000: gravity period at level 0, in clk cycles (1 s at 50 MHz)
- GRAV_STEP, 4000000: period reduction per level
- GRAV_MIN, 5000000: period floor
- DONE_TIMEOUT, 1000000: max cycles waiting for mv_done

- clk  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- key_left  in  1  one-cycle pulse, move left
- key_right  in  1  one-cycle pulse, move right
- key_rot  in  1  one-cycle pulse, rotate
- key_down  in  1  one-cycle pulse, soft drop
- level  in  4  game speed level, 0..15
- pause  in  1  1 = freeze gravity, ignore key pulses, issue nothing new
- cmd_valid  out  1  command offered to board engine
- cmd_op  out  3  1=LEFT 2=RIGHT 3=ROT 4=DOWN 5=GRAV; 0 when cmd_valid=0
- cmd_ready  in  1  board engine accepts command
- mv_done  in  1  one-cycle pulse, board engine finished the command
- timeout_err  out  1  one-cycle pulse, mv_done not received in time

## Operation
- Pending bits pend_{left,right,rot,down,grav}, reset 0. Pulse sets bit; repeated pulses while set merge into one command. Key pulses ignored while pause=1; existing pending bits retained.
- Gravity: 32-bit counter, reset 0. period = max(GRAV_BASE - level*GRAV_STEP, GRAV_MIN), computed in 32 bits, clamped before underflow. Counter increments when pause=0; on reaching period-1 wraps to 0 and sets pend_grav. Level change mid-count: if counter >= new period-1, tick next cycle. Frozen (holds value) while pause=1.
- FSM states IDLE, ISSUE, WAIT_DONE; reset to IDLE.
  - IDLE: if pause=0 and any pend set, select winner, latch cmd_op, go ISSUE.
  - ISSUE: cmd_valid=1, cmd_op stable. On cmd_valid&cmd_ready: clear winner's pend bit, go WAIT_DONE. pause does not withdraw an offered command.
  - WAIT_DONE: cmd_valid=0. On mv_done go IDLE. Cycle counter reaches DONE_TIMEOUT: pulse timeout_err, go IDLE.
- Arbitration: pend_grav always highest priority. Keys resolved per Configuration.
- Same-cycle set and clear of one pend bit (new pulse on grant edge): set wins, bit stays 1.
- mv_done outside WAIT_DONE ignored.
- Reset mid-operation: all pend bits, gravity counter, FSM, outputs return to reset values immediately.
- Output reset values: cmd_valid=0, cmd_op=0, timeout_err=0.

## Timing
- Pulse sampled at edge n -> pend bit 1 after n -> IDLE decides at n+1 -> cmd_valid=1 after edge n+1 (2-cycle latency).
- Transfer at edge where cmd_valid&cmd_ready; cmd_valid=0 next cycle.
- mv_done sampled at edge m -> IDLE after m -> next cmd_valid earliest after m+1.
- Back-to-back commands therefore have at least one IDLE cycle between them.
- All outputs registered.

## Configuration
- KEY_RR_EN defined: round-robin among ROT, LEFT, RIGHT, DOWN; 2-bit pointer, reset to ROT, advances to the position after the granted key on each key transfer (not on GRAV).
- KEY_RR_EN undefined: fixed priority ROT > LEFT > RIGHT > DOWN; no pointer.

## Test plan
- Reset, key_left pulse at cycle 10, cmd_ready=1 -> cmd_valid=1 with cmd_op=1 at cycle 12, one cycle; after mv_done returns to IDLE, no second command.
- key_rot and key_down same cycle, gravity tick pending -> order GRAV(5), ROT(3), DOWN(4).
- KEY_RR_EN: left and right pulsed continuously, each grant immediately re-armed -> cmd_op alternates 1,2,1,2; without macro -> 1,1,1.
- GRAV_BASE=100, GRAV_STEP=10, GRAV_MIN=30, level=9 -> gravity command every 30 cycles plus handshake; pause=1 for 50 cycles freezes counter and issues nothing.
- cmd_ready held 0 for 20 cycles -> cmd_valid and cmd_op stable throughout; key_left pulse on grant edge of LEFT -> second LEFT issued.
- DONE_TIMEOUT=16, no mv_done -> timeout_err pulse 16 cycles after transfer, FSM IDLE; RST low during ISSUE -> cmd_valid=0 immediately.
